fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_stage_pc_unit.sv | 37 +++
 rtl/fetch_stage.sv | 89 ++++++++
 tb/tb_fetch_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants, FSM state type and counter helper for the fetch stage.
// The FETCH_STATS_EN macro enables the redirect/stall counters in fetch_stage.
package fetch_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP    = 32'h0000_0000;
  localparam int          CNT_W        = 16;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_stage_pc_unit.sv
// Program counter register and next-PC selection (hold, jump, branch, PC+4).
// pc drives the instruction memory directly, so there is no added fetch latency.
module pc_unit
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        jump,
  input  logic        branch,
  input  logic [31:0] pc_plus4_d,
  input  logic [31:0] branch_offset,
  input  logic [25:0] jump_index,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  logic [31:0] next_pc;

  assign pc_plus4 = pc + 32'd4;

  // Jump outranks a taken branch. Both targets are based on the ID-stage PC+4.
  always_comb begin
    // NOTE: assigning a default first means every path drives next_pc, so no latch is inferred.
    next_pc = pc_plus4;
    if (hold)        next_pc = pc;
    else if (jump)   next_pc = {pc_plus4_d[31:28], jump_index, 2'b00};
    else if (branch) next_pc = pc_plus4_d + (branch_offset << 2);
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers use non-blocking assignments so every flop samples its pre-edge inputs.
    if (rst) pc <= RESET_VECTOR;
    else     pc <= next_pc;
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC unit, IF/ID pipeline register and BOOT/RUN sequencing.
// Defining FETCH_STATS_EN adds the saturating brTakenCnt, jumpCnt and stallCnt outputs.
module fetch_stage
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             PCSrcS,
  input  logic             jumpS,
  input  logic             FlushS,
  input  logic             stall,
  input  logic [31:0]      branchOffsetD,
  input  logic [25:0]      jumpIndexD,
  output logic [31:0]      instrAddr,
  input  logic [31:0]      instrData,
  output logic [31:0]      instrD,
  output logic [31:0]      pcPlus4D,
`ifdef FETCH_STATS_EN
  output logic [CNT_W-1:0] brTakenCnt,
  output logic [CNT_W-1:0] jumpCnt,
  output logic [CNT_W-1:0] stallCnt,
`endif
  output logic             validD
);

  fetch_state_e state;
  logic [31:0]  pc_plus4;
  logic         run_go;

  // A redirect or fetch is accepted only in an unstalled RUN cycle.
  assign run_go = (state == RUN) && !stall;

  pc_unit u_pc (
    .clk           (clk),
    .rst           (rst),
    .hold          (!run_go),
    .jump          (jumpS),
    .branch        (PCSrcS),
    .pc_plus4_d    (pcPlus4D),
    .branch_offset (branchOffsetD),
    .jump_index    (jumpIndexD),
    .pc            (instrAddr),
    .pc_plus4      (pc_plus4)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      instrD   <= INSTR_NOP;
      pcPlus4D <= RESET_VECTOR;
      validD   <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state  <= RUN;
          validD <= 1'b0;
        end
        RUN: begin
          if (!stall) begin
            pcPlus4D <= pc_plus4;
            if (FlushS) begin
              instrD <= INSTR_NOP;
              validD <= 1'b0;
            end else begin
              instrD <= instrData;
              validD <= 1'b1;
            end
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brTakenCnt <= '0;
      jumpCnt    <= '0;
      stallCnt   <= '0;
    end else if (state == RUN) begin
      if (stall)                 stallCnt   <= sat_inc(stallCnt);
      if (run_go && jumpS)       jumpCnt    <= sat_inc(jumpCnt);
      if (run_go && PCSrcS && !jumpS) brTakenCnt <= sat_inc(brTakenCnt);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, mid-redirect reset,
// and randomized traffic against a cycle-level reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrcS, jumpS, FlushS, stall;
  logic [31:0] branchOffsetD;
  logic [25:0] jumpIndexD;
  logic [31:0] instrAddr, instrData, instrD, pcPlus4D;
  logic        validD;
  logic [15:0] brTakenCnt, jumpCnt, stallCnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instruction memory: each word encodes its own address.
  assign instrData = instrAddr | 32'hA000_0000;

`ifndef FETCH_STATS_EN
  assign brTakenCnt = '0;
  assign jumpCnt    = '0;
  assign stallCnt   = '0;
`endif

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .PCSrcS        (PCSrcS),
    .jumpS         (jumpS),
    .FlushS        (FlushS),
    .stall         (stall),
    .branchOffsetD (branchOffsetD),
    .jumpIndexD    (jumpIndexD),
    .instrAddr     (instrAddr),
    .instrData     (instrData),
    .instrD        (instrD),
    .pcPlus4D      (pcPlus4D),
`ifdef FETCH_STATS_EN
    .brTakenCnt    (brTakenCnt),
    .jumpCnt       (jumpCnt),
    .stallCnt      (stallCnt),
`endif
    .validD        (validD)
  );

  typedef struct {
    logic        stall, flush, pcsrc, jump;
    logic [31:0] off;
    logic [25:0] idx;
    logic [31:0] e_addr, e_instr, e_pc4;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];

  // Reference model state.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_boot;
  logic [15:0] m_br, m_jmp, m_stl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic s, f, p, j, input logic [31:0] off,
                              input logic [25:0] idx, input logic [31:0] a, ins, pc4,
                              input logic v);
    vec_t r;
    r.stall = s; r.flush = f; r.pcsrc = p; r.jump = j; r.off = off; r.idx = idx;
    r.e_addr = a; r.e_instr = ins; r.e_pc4 = pc4; r.e_valid = v;
    return r;
  endfunction

  task automatic drive(input logic s, f, p, j, input logic [31:0] off, input logic [25:0] idx);
    stall = s; FlushS = f; PCSrcS = p; jumpS = j; branchOffsetD = off; jumpIndexD = idx;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " instrAddr"}, instrAddr, 32'h0);
    check({tag, " instrD"},    instrD,    32'h0);
    check({tag, " pcPlus4D"},  pcPlus4D,  32'h0);
    check({tag, " validD"},    {31'b0, validD}, 32'h0);
`ifdef FETCH_STATS_EN
    check({tag, " brTakenCnt"}, {16'b0, brTakenCnt}, 32'h0);
    check({tag, " jumpCnt"},    {16'b0, jumpCnt},    32'h0);
    check({tag, " stallCnt"},   {16'b0, stallCnt},   32'h0);
`endif
  endtask

  // Model of one clock edge, derived from the stage's behavioural rules.
  task automatic model_edge();
    logic [31:0] id_pc4;
    if (m_boot) begin
      m_boot  = 1'b0;
      m_valid = 1'b0;
    end else if (stall) begin
      if (m_stl != 16'hFFFF) m_stl++;
    end else begin
      id_pc4  = m_pc4;
      m_pc4   = m_pc + 32'd4;
      m_instr = FlushS ? 32'h0 : (m_pc | 32'hA000_0000);
      m_valid = !FlushS;
      if (jumpS) begin
        m_pc = {id_pc4[31:28], jumpIndexD, 2'b00};
        if (m_jmp != 16'hFFFF) m_jmp++;
      end else if (PCSrcS) begin
        m_pc = id_pc4 + branchOffsetD * 32'd4;
        if (m_br != 16'hFFFF) m_br++;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    rst = 1'b1;

    // Directed table: inputs held across one edge, outputs expected after it.
    vecs.push_back(mk(0,0,0,0, 32'h0,        26'h0,   32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0));
    vecs.push_back(mk(0,0,0,0, 32'h0,        26'h0,   32'h0000_0004, 32'hA000_0000, 32'h0000_0004, 1));
    vecs.push_back(mk(0,0,0,0, 32'h0,        26'h0,   32'h0000_0008, 32'hA000_0004, 32'h0000_0008, 1));
    vecs.push_back(mk(0,0,0,0, 32'h0,        26'h0,   32'h0000_000C, 32'hA000_0008, 32'h0000_000C, 1));
    vecs.push_back(mk(0,0,0,0, 32'h0,        26'h0,   32'h0000_0010, 32'hA000_000C, 32'h0000_0010, 1));
    vecs.push_back(mk(0,1,1,0, 32'h3,        26'h0,   32'h0000_001C, 32'h0000_0000, 32'h0000_0014, 0));
    vecs.push_back(mk(0,0,0,0, 32'h0,        26'h0,   32'h0000_0020, 32'hA000_001C, 32'h0000_0020, 1));
    vecs.push_back(mk(1,1,0,0, 32'h0,        26'h0,   32'h0000_0020, 32'hA000_001C, 32'h0000_0020, 1));
    vecs.push_back(mk(1,1,0,0, 32'h0,        26'h0,   32'h0000_0020, 32'hA000_001C, 32'h0000_0020, 1));
    vecs.push_back(mk(1,1,0,0, 32'h0,        26'h0,   32'h0000_0020, 32'hA000_001C, 32'h0000_0020, 1));
    vecs.push_back(mk(0,1,1,0, 32'h0FFF_FFFB, 26'h0,  32'h4000_000C, 32'h0000_0000, 32'h0000_0024, 0));
    vecs.push_back(mk(0,0,0,0, 32'h0,        26'h0,   32'h4000_0010, 32'hE000_000C, 32'h4000_0010, 1));
    vecs.push_back(mk(0,1,1,1, 32'h3,        26'h100, 32'h4000_0400, 32'h0000_0000, 32'h4000_0014, 0));
    vecs.push_back(mk(0,0,0,0, 32'h0,        26'h0,   32'h4000_0404, 32'hE000_0400, 32'h4000_0404, 1));
    vecs.push_back(mk(0,1,1,0, 32'h2FFF_FEFE, 26'h0,  32'hFFFF_FFFC, 32'h0000_0000, 32'h4000_0408, 0));
    vecs.push_back(mk(0,0,0,0, 32'h0,        26'h0,   32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 1));
    vecs.push_back(mk(0,0,0,0, 32'h0,        26'h0,   32'h0000_0004, 32'hA000_0000, 32'h0000_0004, 1));
    vecs.push_back(mk(0,0,0,0, 32'h0,        26'h0,   32'h0000_0008, 32'hA000_0004, 32'h0000_0008, 1));
    vecs.push_back(mk(0,1,1,0, 32'hFFFF_FFFF, 26'h0,  32'h0000_0004, 32'h0000_0000, 32'h0000_000C, 0));
    vecs.push_back(mk(0,0,0,0, 32'h0,        26'h0,   32'h0000_0008, 32'hA000_0004, 32'h0000_0008, 1));

    #2;
    check_reset_state("reset");
    tick();
    rst = 1'b0;
    check("boot instrAddr", instrAddr, 32'h0);
    check("boot validD", {31'b0, validD}, 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].stall, vecs[i].flush, vecs[i].pcsrc, vecs[i].jump, vecs[i].off, vecs[i].idx);
      tick();
      check($sformatf("vec%0d instrAddr", i), instrAddr, vecs[i].e_addr);
      check($sformatf("vec%0d instrD", i),    instrD,    vecs[i].e_instr);
      check($sformatf("vec%0d pcPlus4D", i),  pcPlus4D,  vecs[i].e_pc4);
      check($sformatf("vec%0d validD", i),    {31'b0, validD}, {31'b0, vecs[i].e_valid});
`ifdef FETCH_STATS_EN
      if (i == 9) check("stallCnt after 3 stalls", {16'b0, stallCnt}, 32'd3);
`endif
    end
`ifdef FETCH_STATS_EN
    check("brTakenCnt", {16'b0, brTakenCnt}, 32'd4);
    check("jumpCnt",    {16'b0, jumpCnt},    32'd1);
    check("stallCnt",   {16'b0, stallCnt},   32'd3);
`endif

    // Reset pulsed while a branch redirect is being presented.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 26'h0);
    #3;
    rst = 1'b1;
    #1;
    check_reset_state("midreset");
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    rst = 1'b0;
    check("postrst instrAddr0", instrAddr, 32'h0);
    tick();
    check("postrst instrAddr1", instrAddr, 32'h0);
    check("postrst validD1", {31'b0, validD}, 32'h0);
    tick();
    check("postrst instrAddr2", instrAddr, 32'h4);
    check("postrst instrD2", instrD, 32'hA000_0000);
    check("postrst validD2", {31'b0, validD}, 32'h1);

    // Randomized traffic against the reference model, starting from a fresh reset.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_boot = 1'b1;
    m_br = '0; m_jmp = '0; m_stl = '0;
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
            $urandom_range(7) == 0,
            ($urandom_range(1) == 0) ? 32'($signed(8'($urandom))) : 32'($urandom),
            26'($urandom));
      @(posedge clk);
      model_edge();
      #1;
      check("rand instrAddr", instrAddr, m_pc);
      check("rand instrD",    instrD,    m_instr);
      check("rand pcPlus4D",  pcPlus4D,  m_pc4);
      check("rand validD",    {31'b0, validD}, {31'b0, m_valid});
`ifdef FETCH_STATS_EN
      check("rand brTakenCnt", {16'b0, brTakenCnt}, {16'b0, m_br});
      check("rand jumpCnt",    {16'b0, jumpCnt},    {16'b0, m_jmp});
      check("rand stallCnt",   {16'b0, stallCnt},   {16'b0, m_stl});
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
